or_gate: RTL and testbench
==========================

# or_gate

Two-input OR primitive with a cycle-registered shadow and truth-table activity monitoring. Output `O` is the pure combinational OR of `A` and `B` and is valid with no clock running. Clocked side outputs give a registered copy, edge pulses, a saturating high-cycle count and a truth-table row coverage mask. The block is the basic logic-gate building block used by the introductory gate exercises and their waveform-dump stimulus benches.

## Interface
- `WIDTH`, default 1: bit width of `A`, `B`, `O`, `O_q`; OR is bitwise.
- `CNT_W`, default 16: width of `high_cnt`.
- `clk` input 1: single clock, rising-edge active.
- `rst_n` input 1: reset, synchronous and active-low.
- `A` input WIDTH: operand A.
- `B` input WIDTH: operand B.
- `O` output WIDTH: `A | B`, combinational.
- `O_q` output WIDTH: `O` registered one cycle.
- `rise` output 1: one-cycle pulse when bit 0 of `O` goes 0 to 1.
- `fall` output 1: one-cycle pulse when bit 0 of `O` goes 1 to 0.
- `high_cnt` output CNT_W: count of clock cycles with `O[0]` = 1; saturates.
- `rows_seen` output 4: sticky truth-table coverage of bit 0. Bit index = {A[0],B[0]}: bit0 = 00, bit1 = 01, bit2 = 10, bit3 = 11.
- `all_rows` output 1: high when `rows_seen` = 4'b1111.

## Operation
- `O = A | B` bitwise.
  - No clock or reset dependency.
  - Holds while `rst_n` = 0 and when `clk` is stopped.
  - For WIDTH=1: 00→0, 01→1, 10→1, 11→1.
- Reset: on a rising edge with `rst_n` = 0, all clocked state clears.
  - `O_q` = 0, `high_cnt` = 0, `rows_seen` = 0.
  - Internal previous-value register = 0, so `rise` = `fall` = 0.
- `O_q`: on each rising edge out of reset, `O_q <= O`.
- Edge detection:
  - `rise` = `O[0] & ~prev`; `fall` = `~O[0] & prev`.
  - `prev` is `O[0]` sampled at the previous edge.
  - Both are registered, so each pulse lasts exactly one cycle.
- `high_cnt`:
  - Increments by 1 on each edge where `O[0]` = 1.
  - Holds at 2^CNT_W−1 and never wraps.
- `rows_seen`:
  - On each edge, sets the bit indexed by {A[0],B[0]}.
  - Bits clear only on reset.
- `all_rows` is combinational from `rows_seen`.
- Upper bits of wide operands affect only `O` and `O_q`.
- X/Z on inputs is not masked; it propagates.

## Timing
- `O` has zero-cycle latency: it follows `A`/`B` within the same time step.
- `O_q`, `rise`, `fall`, `high_cnt`, `rows_seen` have 1-cycle latency, updating on the rising edge after the input change.
- Reset asserted mid-operation takes effect at the next rising edge.
  - `O` keeps tracking the inputs throughout.
  - On the first edge after `rst_n` returns to 1, sampling resumes normally.
  - A `rise` pulse is generated if `O[0]` = 1 at that edge, since `prev` = 0.
- Inputs toggling between edges affect only `O`; only the value present at the edge is recorded.
- Saturation boundary:
  - At `high_cnt` = max with `O[0]` = 1, the value holds.
  - With `O[0]` = 0, the value holds as normal.

## Test plan
- Combinational truth table, clock idle, WIDTH=1: drive AB = 00, 01, 10, 11 with 50 time units each → `O` = 0, 1, 1, 1, each valid immediately.
- Reset with clock running:
  - Hold `rst_n`=0 with AB=11 for 3 edges → `O`=1, `O_q`=0, `high_cnt`=0, `rows_seen`=0000, `rise`=0.
  - Release → after 1 edge `O_q`=1, `rise`=1 for one cycle, `high_cnt`=1.
- Edge pulses: AB 00→01 held 4 cycles, then →00 → `rise` high for exactly 1 cycle one edge after the change; `fall` likewise after the return; `high_cnt`=4.
- Coverage: apply AB 00, 01, 10, 11 for one cycle each → `rows_seen` progresses 0001, 0011, 0111, 1111; `all_rows`=1 from the 4th edge and remains 1 until reset.
- Saturation: CNT_W=3, hold AB=10 for 10 cycles → `high_cnt` reaches 7 and stays 7.
- Wide operand: WIDTH=8, A=8'hA0, B=8'h05 → `O`=8'hA5 immediately, `O_q`=8'hA5 one edge later; A=B=0 → `O`=8'h00.

Source files
------------

// File: rtl/or_gate.sv
// Two-input bitwise OR with a registered shadow copy, bit-0 edge pulses,
// a saturating high-cycle counter and sticky truth-table row coverage.
module or_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] O_q,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] high_cnt,
  output logic [3:0]       rows_seen,
  output logic             all_rows
);

  logic       prev;
  logic [1:0] row_idx;

  // The gate itself is purely combinational so it works with the clock stopped.
  assign O        = A | B;
  assign row_idx  = {A[0], B[0]};
  assign all_rows = &rows_seen;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      O_q       <= '0;
      prev      <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      high_cnt  <= '0;
      rows_seen <= '0;
    end else begin
      O_q  <= O;
      prev <= O[0];
      rise <= O[0] & ~prev;
      fall <= ~O[0] & prev;
      // Counter sticks at all-ones rather than wrapping back to zero.
      if (O[0] && (high_cnt != {CNT_W{1'b1}}))
        high_cnt <= high_cnt + 1'b1;
      rows_seen[row_idx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_or_gate.sv
// Bench for or_gate: an 8-bit/16-bit-counter instance and a 1-bit/3-bit-counter
// instance share stimulus and are checked against a spec-level model.
module tb_or_gate;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic [7:0]  o_w, oq_w;
  logic        rise_w, fall_w, all_w;
  logic [15:0] cnt_w;
  logic [3:0]  rows_w;

  logic        o_s, oq_s;
  logic        rise_s, fall_s, all_s;
  logic [2:0]  cnt_s;
  logic [3:0]  rows_s;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] m_oq;
  logic       m_prev, m_rise, m_fall;
  int         m_cnt, m_cnt_s;
  logic [3:0] m_rows;
  logic [7:0] exp_q[$];

  or_gate #(.WIDTH(8), .CNT_W(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .O(o_w), .O_q(oq_w),
    .rise(rise_w), .fall(fall_w), .high_cnt(cnt_w), .rows_seen(rows_w),
    .all_rows(all_w)
  );

  or_gate #(.WIDTH(1), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .A(a[0]), .B(b[0]), .O(o_s), .O_q(oq_s),
    .rise(rise_s), .fall(fall_s), .high_cnt(cnt_s), .rows_seen(rows_s),
    .all_rows(all_s)
  );

  // clock/reset block: clock only toggles while enabled
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic model_edge();
    logic [7:0] o;
    o = a | b;
    if (!rst_n) begin
      m_oq = '0; m_prev = 0; m_rise = 0; m_fall = 0;
      m_cnt = 0; m_cnt_s = 0; m_rows = '0;
    end else begin
      m_rise = (o[0] == 1'b1) && (m_prev == 1'b0);
      m_fall = (o[0] == 1'b0) && (m_prev == 1'b1);
      m_prev = o[0];
      m_oq   = o;
      if (o[0]) begin
        m_cnt   = (m_cnt   < 65535) ? m_cnt + 1   : 65535;
        m_cnt_s = (m_cnt_s < 7)     ? m_cnt_s + 1 : 7;
      end
      m_rows[{a[0], b[0]}] = 1'b1;
    end
    exp_q.push_back(m_oq);
  endtask

  // driver: wait for an edge, advance the model, sample 1 unit later
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; a = '0; b = '0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_truth_table();
    logic [1:0] ab;
    for (int i = 0; i < 4; i++) begin
      ab = i[1:0];
      a = {7'd0, ab[1]};
      b = {7'd0, ab[0]};
      #1;
      n_vec++;
      if (o_w !== {7'd0, (ab != 2'b00)} || o_s !== (ab != 2'b00)) begin
        n_err++;
        $display("FAIL truth_table ab=%b: O=%h/%b want %b", ab, o_w, o_s, ab != 2'b00);
      end
      #49;
    end
  endtask

  task automatic test_reset();
    clk_en = 1;
    rst_n = 0; a = 8'h01; b = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (o_w !== 8'h01 || oq_w !== 8'h00 || cnt_w !== 16'd0 || rows_w !== 4'b0000 ||
          rise_w !== 1'b0 || fall_w !== 1'b0 || cnt_s !== 3'd0) begin
        n_err++;
        $display("FAIL reset_hold: O=%h O_q=%h cnt=%0d rows=%b rise=%b fall=%b want 01 00 0 0000 0 0",
                 o_w, oq_w, cnt_w, rows_w, rise_w, fall_w);
      end
    end
    rst_n = 1;
    tick();
    n_vec++;
    if (oq_w !== 8'h01 || rise_w !== 1'b1 || cnt_w !== 16'd1 || rows_w !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_release: O_q=%h rise=%b cnt=%0d rows=%b want 01 1 1 1000",
               oq_w, rise_w, cnt_w, rows_w);
    end
    tick();
    n_vec++;
    if (rise_w !== 1'b0 || cnt_w !== 16'd2) begin
      n_err++;
      $display("FAIL reset_after: rise=%b cnt=%0d want 0 2", rise_w, cnt_w);
    end
  endtask

  task automatic test_edges();
    logic exp_rise, exp_fall;
    do_reset();
    tick();
    a = 8'h00; b = 8'h01;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) b = 8'h00;
      tick();
      exp_rise = (i == 0);
      exp_fall = (i == 4);
      n_vec++;
      if (rise_w !== exp_rise || fall_w !== exp_fall || rise_s !== exp_rise || fall_s !== exp_fall) begin
        n_err++;
        $display("FAIL edge_pulse cyc=%0d: rise=%b/%b fall=%b/%b want %b %b",
                 i, rise_w, rise_s, fall_w, fall_s, exp_rise, exp_fall);
      end
    end
    n_vec++;
    if (cnt_w !== 16'd4 || cnt_s !== 3'd4) begin
      n_err++;
      $display("FAIL edge_count: cnt=%0d/%0d want 4", cnt_w, cnt_s);
    end
  endtask

  task automatic test_coverage();
    logic [3:0] exp_rows;
    do_reset();
    exp_rows = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        a = {7'd0, i[1]}; b = {7'd0, i[0]};
        exp_rows = exp_rows | (4'b0001 << i);
      end else begin
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      end
      tick();
      n_vec++;
      if (rows_w !== exp_rows || rows_s !== exp_rows ||
          all_w !== (exp_rows == 4'hF) || all_s !== (exp_rows == 4'hF)) begin
        n_err++;
        $display("FAIL coverage step=%0d: rows=%b/%b all=%b/%b want %b",
                 i, rows_w, rows_s, all_w, all_s, exp_rows);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    a = 8'h01; b = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_vec++;
      if (cnt_s !== 3'((i < 7) ? i : 7) || cnt_w !== 16'(i)) begin
        n_err++;
        $display("FAIL saturation cyc=%0d: cnt_s=%0d cnt_w=%0d want %0d %0d",
                 i, cnt_s, cnt_w, (i < 7) ? i : 7, i);
      end
    end
    a = 8'h00;
    tick();
    n_vec++;
    if (cnt_s !== 3'd7) begin
      n_err++;
      $display("FAIL saturation_hold_low: cnt_s=%0d want 7", cnt_s);
    end
  endtask

  task automatic test_wide();
    a = 8'hA0; b = 8'h05;
    #1;
    n_vec++;
    if (o_w !== 8'hA5) begin
      n_err++;
      $display("FAIL wide_comb: O=%h want a5", o_w);
    end
    tick();
    n_vec++;
    if (oq_w !== 8'hA5) begin
      n_err++;
      $display("FAIL wide_reg: O_q=%h want a5", oq_w);
    end
    a = 8'h00; b = 8'h00;
    #1;
    n_vec++;
    if (o_w !== 8'h00) begin
      n_err++;
      $display("FAIL wide_zero: O=%h want 00", o_w);
    end
  endtask

  // randomized traffic incl. mid-cycle glitches and occasional resets
  task automatic test_random();
    logic [7:0] exp_oq;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      rst_n = ($urandom_range(0, 29) != 0);
      #1;
      n_vec++;
      if (o_w !== (a | b) || o_s !== (a[0] | b[0])) begin
        n_err++;
        $display("FAIL rand_comb i=%0d: O=%h/%b want %h", i, o_w, o_s, a | b);
      end
      if ($urandom_range(0, 1) == 1) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
      tick();
      exp_oq = exp_q.pop_front();
      n_vec++;
      if (oq_w !== exp_oq || oq_s !== exp_oq[0] || rise_w !== m_rise || fall_w !== m_fall ||
          rise_s !== m_rise || fall_s !== m_fall || cnt_w !== 16'(m_cnt) ||
          cnt_s !== 3'(m_cnt_s) || rows_w !== m_rows || rows_s !== m_rows ||
          all_w !== (m_rows == 4'hF) || all_s !== (m_rows == 4'hF)) begin
        n_err++;
        $display("FAIL rand_seq i=%0d: O_q=%h rise=%b fall=%b cnt=%0d/%0d rows=%b all=%b want %h %b %b %0d/%0d %b",
                 i, oq_w, rise_w, fall_w, cnt_w, cnt_s, rows_w, all_w,
                 exp_oq, m_rise, m_fall, m_cnt, m_cnt_s, m_rows);
      end
    end
  endtask

  initial begin
    test_truth_table();
    test_reset();
    test_edges();
    test_coverage();
    test_saturation();
    test_wide();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
